// File: rtl/alu_pkg.sv
// Shared ALU control codes and sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_PASSB = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b0001;
  localparam logic [3:0] ALU_SUB   = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_XOR   = 4'b1101;
  localparam logic [3:0] ALU_NOR   = 4'b1110;
  localparam logic [3:0] ALU_SRA   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // True for the ops handled by the iterative shifter.
  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_core_comb.sv
// Single-cycle datapath: add/sub/logic/slt/pass-B with flags and illegal decode.
module alu_core_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_c,
  output logic             carry_c,
  output logic             overflow_c,
  output logic             illegal_c
);

  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] diff_c;
  logic             slt_c;

  assign sum_c  = {1'b0, a} + {1'b0, b};
  assign diff_c = a - b;
  assign slt_c  = $signed(a) < $signed(b);

  // Op select; shift codes yield zero here since the sequencer owns them.
  always_comb begin
    result_c   = '0;
    carry_c    = 1'b0;
    overflow_c = 1'b0;
    illegal_c  = 1'b0;
    case (op)
      ALU_ADD: begin
        result_c   = sum_c[WIDTH-1:0];
        carry_c    = sum_c[WIDTH];
        overflow_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result_c   = diff_c;
        carry_c    = a < b;
        overflow_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:   result_c = a & b;
      ALU_OR:    result_c = a | b;
      ALU_XOR:   result_c = a ^ b;
      ALU_NOR:   result_c = ~(a | b);
      ALU_SLT:   result_c = {{(WIDTH-1){1'b0}}, slt_c};
      ALU_PASSB: result_c = b;
      ALU_SLL, ALU_SRL, ALU_SRA: result_c = '0;
      default:   illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/seq_alu_unit.sv
// Multi-cycle execution unit: start/done sequencer plus 1-bit-per-cycle shifter.
module seq_alu_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [SHW-1:0]   cnt;

  logic [SHW-1:0]   amt_c;
  logic [WIDTH-1:0] core_result_c;
  logic             core_carry_c;
  logic             core_overflow_c;
  logic             core_illegal_c;
  logic [WIDTH-1:0] exec_result_c;

  assign amt_c = b[SHW-1:0];

  alu_core_comb #(.WIDTH(WIDTH)) u_core (
    .op         (op_q),
    .a          (a_q),
    .b          (b_q),
    .result_c   (core_result_c),
    .carry_c    (core_carry_c),
    .overflow_c (core_overflow_c),
    .illegal_c  (core_illegal_c)
  );

  // A shift by zero passes operand A through the EXEC path.
  assign exec_result_c = is_shift(op_q) ? a_q : core_result_c;

  // One-bit shift step; sra replicates the sign bit.
  function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] op, input logic [WIDTH-1:0] x);
    case (op)
      ALU_SLL: return {x[WIDTH-2:0], 1'b0};
      ALU_SRA: return {x[WIDTH-1], x[WIDTH-1:1]};
      default: return {1'b0, x[WIDTH-1:1]};
    endcase
  endfunction

  // Sequencer: accept, single-cycle exec or iterative shift, then registered done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= control;
            b_q  <= b;
            busy <= 1'b1;
            if (is_shift(control) && (amt_c != '0)) begin
              a_q   <= shift_one(control, a);
              cnt   <= amt_c - SHW'(1);
              state <= SHIFT;
            end else begin
              a_q   <= a;
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          result   <= exec_result_c;
          zero     <= (exec_result_c == '0);
          carry    <= core_carry_c;
          overflow <= core_overflow_c;
          illegal  <= core_illegal_c;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        SHIFT: begin
          if (cnt == '0) begin
            result   <= a_q;
            zero     <= (a_q == '0);
            carry    <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            a_q <= shift_one(op_q, a_q);
            cnt <= cnt - SHW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
